// File: rtl/usb_serial_tx_fifo_pkg.sv
// Shared constants and output-FSM state encoding for the USB serial transmit FIFO.
package usb_serial_pkg;

    localparam logic [7:0] ASCII_CR = 8'h0D;
    localparam logic [7:0] ASCII_LF = 8'h0A;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        HOLD    = 2'd1,
        CR_PEND = 2'd2
    } tx_state_t;

endpackage

// File: rtl/usb_serial_tx_fifo_if.sv
// Write-side, status and endpoint handshake signals of the transmit FIFO.
interface usb_serial_tx_fifo_if #(
    parameter int DEPTH_LOG2 = 4
);
    logic [7:0]          wr_data;
    logic                wr_en;
    logic                wr_full;
    logic [DEPTH_LOG2:0] wr_level;
    logic                overflow;
    logic                clr_overflow;
    logic                uart_tx_ready;
    logic [7:0]          uart_tx_data;
    logic                uart_tx_strobe;

    modport slave (
        input  wr_data, wr_en, clr_overflow, uart_tx_ready,
        output wr_full, wr_level, overflow, uart_tx_data, uart_tx_strobe
    );

    modport master (
        output wr_data, wr_en, clr_overflow, uart_tx_ready,
        input  wr_full, wr_level, overflow, uart_tx_data, uart_tx_strobe
    );
endinterface

// File: rtl/usb_serial_tx_fifo_mem.sv
// Byte storage, one write port and a combinational read port (data follows i_rd_addr same cycle).
module usb_serial_fifo_mem #(
    parameter int DEPTH_LOG2 = 4
) (
    input  logic                  clk,
    input  logic                  i_wr_en,
    input  logic [DEPTH_LOG2-1:0] i_wr_addr,
    input  logic [7:0]            i_wr_data,
    input  logic [DEPTH_LOG2-1:0] i_rd_addr,
    output logic [7:0]            o_rd_data
);
    logic [7:0] r_mem [2**DEPTH_LOG2];

    always_ff @(posedge clk) begin
        if (i_wr_en) begin
            r_mem[i_wr_addr] <= i_wr_data;
        end
    end

    assign o_rd_data = r_mem[i_rd_addr];
endmodule

// File: rtl/usb_serial_tx_fifo.sv
// Byte FIFO feeding the USB serial endpoint: write-to-strobe 2 cycles, at most one strobe per 2 cycles, waits on uart_tx_ready.
// Build option USB_SERIAL_TX_FIFO_CRLF_EN inserts a CR strobe ahead of every LF.
module usb_serial_tx_fifo
    import usb_serial_pkg::*;
#(
    parameter int DEPTH_LOG2 = 4
) (
    input logic                 clk,
    input logic                 reset,
    usb_serial_tx_fifo_if.slave bus
);
    localparam logic [DEPTH_LOG2:0]   LVL_FULL = {1'b1, {DEPTH_LOG2{1'b0}}};
    localparam logic [DEPTH_LOG2:0]   LVL_ONE  = (DEPTH_LOG2+1)'(1);
    localparam logic [DEPTH_LOG2-1:0] PTR_ONE  = DEPTH_LOG2'(1);

    tx_state_t             r_state;
    tx_state_t             w_state_nxt;
    logic [DEPTH_LOG2-1:0] r_wptr;
    logic [DEPTH_LOG2-1:0] r_rptr;
    logic [DEPTH_LOG2:0]   r_level;
    logic                  r_overflow;
    logic                  r_strobe;
    logic [7:0]            r_data;
    logic                  w_strobe_nxt;
    logic [7:0]            w_data_nxt;
    logic                  w_pop;
    logic                  w_full;
    logic                  w_wr_acc;
    logic [7:0]            w_rd_data;
`ifdef USB_SERIAL_TX_FIFO_CRLF_EN
    logic                  r_cr_pend;
    logic                  w_cr_pend_nxt;
`endif

    // Full is judged on the pre-edge level, so a same-cycle pop never rescues a write.
    assign w_full   = (r_level == LVL_FULL);
    assign w_wr_acc = reset & bus.wr_en & ~w_full;

    usb_serial_fifo_mem #(
        .DEPTH_LOG2 (DEPTH_LOG2)
    ) u_mem (
        .clk       (clk),
        .i_wr_en   (w_wr_acc),
        .i_wr_addr (r_wptr),
        .i_wr_data (bus.wr_data),
        .i_rd_addr (r_rptr),
        .o_rd_data (w_rd_data)
    );

    always_comb begin
        w_state_nxt   = r_state;
        w_strobe_nxt  = 1'b0;
        w_data_nxt    = r_data;
        w_pop         = 1'b0;
`ifdef USB_SERIAL_TX_FIFO_CRLF_EN
        w_cr_pend_nxt = r_cr_pend;
`endif
        case (r_state)
            IDLE: begin
                if (r_level != '0 && bus.uart_tx_ready) begin
                    w_strobe_nxt = 1'b1;
                    w_state_nxt  = HOLD;
`ifdef USB_SERIAL_TX_FIFO_CRLF_EN
                    if (w_rd_data == ASCII_LF) begin
                        w_data_nxt    = ASCII_CR;
                        w_cr_pend_nxt = 1'b1;
                    end else begin
                        w_data_nxt = w_rd_data;
                        w_pop      = 1'b1;
                    end
`else
                    w_data_nxt = w_rd_data;
                    w_pop      = 1'b1;
`endif
                end
            end
            HOLD: begin
`ifdef USB_SERIAL_TX_FIFO_CRLF_EN
                w_state_nxt = r_cr_pend ? CR_PEND : IDLE;
`else
                w_state_nxt = IDLE;
`endif
            end
            CR_PEND: begin
`ifdef USB_SERIAL_TX_FIFO_CRLF_EN
                // The LF is still at the head: it is popped only now, after its CR went out.
                if (bus.uart_tx_ready) begin
                    w_strobe_nxt  = 1'b1;
                    w_data_nxt    = ASCII_LF;
                    w_pop         = 1'b1;
                    w_cr_pend_nxt = 1'b0;
                    w_state_nxt   = HOLD;
                end
`else
                w_state_nxt = IDLE;
`endif
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state    <= IDLE;
            r_wptr     <= '0;
            r_rptr     <= '0;
            r_level    <= '0;
            r_overflow <= 1'b0;
            r_strobe   <= 1'b0;
            r_data     <= 8'h00;
`ifdef USB_SERIAL_TX_FIFO_CRLF_EN
            r_cr_pend  <= 1'b0;
`endif
        end else begin
            r_state  <= w_state_nxt;
            r_strobe <= w_strobe_nxt;
            r_data   <= w_data_nxt;
`ifdef USB_SERIAL_TX_FIFO_CRLF_EN
            r_cr_pend <= w_cr_pend_nxt;
`endif
            if (w_wr_acc) begin
                r_wptr <= r_wptr + PTR_ONE;
            end
            if (w_pop) begin
                r_rptr <= r_rptr + PTR_ONE;
            end
            case ({w_wr_acc, w_pop})
                2'b10:   r_level <= r_level + LVL_ONE;
                2'b01:   r_level <= r_level - LVL_ONE;
                default: r_level <= r_level;
            endcase
            if (bus.wr_en && w_full) begin
                r_overflow <= 1'b1;
            end else if (bus.clr_overflow) begin
                r_overflow <= 1'b0;
            end
        end
    end

    assign bus.wr_full        = w_full;
    assign bus.wr_level       = r_level;
    assign bus.overflow       = r_overflow;
    assign bus.uart_tx_data   = r_data;
    assign bus.uart_tx_strobe = r_strobe;
endmodule

// File: tb/tb_usb_serial_tx_fifo.sv
// Randomized and directed bench for usb_serial_tx_fifo against a queue-based reference model.
module tb_usb_serial_tx_fifo;
    localparam int DEPTH = 16;

    logic clk;
    logic reset;
    int   n_chk;
    int   n_fail;
    int   cyc;
    int   n_stb;
    bit   chk_en;

    usb_serial_tx_fifo_if #(.DEPTH_LOG2(4)) bus ();

    usb_serial_tx_fifo #(.DEPTH_LOG2(4)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: the FIFO contents as a queue plus the emission pacing rules.
    logic [7:0] m_q [$];
    bit         m_ovf;
    bit         m_stb;
    logic [7:0] m_dat;
    bit         m_cool;
    bit         m_crp;
    bit         m_full;

    logic [7:0] s_q   [$];
    int         s_cyc [$];
    logic [7:0] exp_q [$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    always @(posedge clk) begin
        cyc++;
        if (!reset) begin
            m_q.delete();
            m_ovf  = 1'b0;
            m_stb  = 1'b0;
            m_dat  = 8'h00;
            m_cool = 1'b0;
            m_crp  = 1'b0;
        end else begin
            m_full = (m_q.size() == DEPTH);
            m_stb  = 1'b0;
            if (m_cool) begin
                m_cool = 1'b0;
            end else if (bus.uart_tx_ready && (m_crp || m_q.size() > 0)) begin
                m_stb  = 1'b1;
                m_cool = 1'b1;
                if (m_crp) begin
                    m_dat = 8'h0A;
                    void'(m_q.pop_front());
                    m_crp = 1'b0;
                end
`ifdef USB_SERIAL_TX_FIFO_CRLF_EN
                else if (m_q[0] == 8'h0A) begin
                    m_dat = 8'h0D;
                    m_crp = 1'b1;
                end
`endif
                else begin
                    m_dat = m_q.pop_front();
                end
            end
            if (bus.wr_en && !m_full) m_q.push_back(bus.wr_data);
            if (bus.wr_en && m_full) m_ovf = 1'b1;
            else if (bus.clr_overflow) m_ovf = 1'b0;
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            check("strobe",   {31'd0, bus.uart_tx_strobe}, {31'd0, m_stb});
            check("data",     {24'd0, bus.uart_tx_data}, {24'd0, m_dat});
            check("level",    {27'd0, bus.wr_level}, m_q.size());
            check("full",     {31'd0, bus.wr_full}, {31'd0, (m_q.size() == DEPTH)});
            check("overflow", {31'd0, bus.overflow}, {31'd0, m_ovf});
            if (bus.uart_tx_strobe === 1'b1) begin
                n_stb++;
                s_q.push_back(bus.uart_tx_data);
                s_cyc.push_back(cyc);
            end
        end
    end

    task automatic tick(input int n = 1);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wr(input logic [7:0] d);
        bus.wr_en   = 1'b1;
        bus.wr_data = d;
        tick();
        bus.wr_en   = 1'b0;
    endtask

    task automatic clear_stream();
        s_q.delete();
        s_cyc.delete();
        exp_q.delete();
    endtask

    task automatic check_stream(input string name);
        check({name, "_len"}, s_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < s_q.size(); i++) begin
            check(name, {24'd0, s_q[i]}, {24'd0, exp_q[i]});
        end
    endtask

    initial begin
        int idx;
        int c;
        n_chk  = 0;
        n_fail = 0;
        cyc    = 0;
        n_stb  = 0;
        chk_en = 1'b0;
        reset  = 1'b0;
        bus.wr_en         = 1'b1;
        bus.wr_data       = 8'h55;
        bus.clr_overflow  = 1'b0;
        bus.uart_tx_ready = 1'b1;

        // Reset held with write and ready active
        tick();
        chk_en = 1'b1;
        tick(2);
        bus.wr_en = 1'b0;
        reset     = 1'b1;
        tick();
        check("rst_level", {27'd0, bus.wr_level}, 32'd0);
        check("rst_no_strobe", n_stb, 32'd0);
        check("rst_overflow", {31'd0, bus.overflow}, 32'd0);

        // Basic drain with one idle cycle between strobes
        clear_stream();
        wr(8'h41);
        wr(8'h42);
        wr(8'h43);
        tick(10);
        exp_q = '{8'h41, 8'h42, 8'h43};
        check_stream("basic");
        if (s_cyc.size() == 3) begin
            check("basic_gap0", s_cyc[1] - s_cyc[0], 32'd2);
            check("basic_gap1", s_cyc[2] - s_cyc[1], 32'd2);
        end
        check("basic_level", {27'd0, bus.wr_level}, 32'd0);

        // Backpressure
        clear_stream();
        bus.uart_tx_ready = 1'b0;
        for (int i = 0; i < 5; i++) wr(8'h50 + 8'(i));
        tick(20);
        check("bp_no_strobe", s_q.size(), 32'd0);
        check("bp_level", {27'd0, bus.wr_level}, 32'd5);
        bus.uart_tx_ready = 1'b1;
        tick(15);
        exp_q = '{8'h50, 8'h51, 8'h52, 8'h53, 8'h54};
        check_stream("bp");

        // Full and overflow
        clear_stream();
        bus.uart_tx_ready = 1'b0;
        for (int i = 0; i < 17; i++) wr(8'h80 + 8'(i));
        check("ovf_full", {31'd0, bus.wr_full}, 32'd1);
        check("ovf_level", {27'd0, bus.wr_level}, 32'd16);
        check("ovf_set", {31'd0, bus.overflow}, 32'd1);
        bus.clr_overflow = 1'b1;
        tick();
        bus.clr_overflow = 1'b0;
        check("ovf_clr", {31'd0, bus.overflow}, 32'd0);
        // Set beats clear; the write is dropped even though a pop happens on the same edge
        bus.clr_overflow  = 1'b1;
        bus.uart_tx_ready = 1'b1;
        wr(8'hEE);
        bus.clr_overflow = 1'b0;
        check("ovf_set_wins", {31'd0, bus.overflow}, 32'd1);
        tick(40);
        for (int i = 0; i < 16; i++) exp_q.push_back(8'h80 + 8'(i));
        check_stream("ovf_drain");
        bus.clr_overflow = 1'b1;
        tick();
        bus.clr_overflow = 1'b0;

        // Wrap with concurrent writes and pops, ready toggling every 3 cycles
        clear_stream();
        idx = 0;
        c   = 0;
        while (idx < 40 && c < 2000) begin
            bus.uart_tx_ready = ((c / 3) % 2) == 0;
            if (m_q.size() < DEPTH) begin
                bus.wr_en   = 1'b1;
                bus.wr_data = 8'(idx);
                idx++;
            end else begin
                bus.wr_en = 1'b0;
            end
            tick();
            c++;
        end
        bus.wr_en = 1'b0;
        check("wrap_all_written", idx, 32'd40);
        bus.uart_tx_ready = 1'b1;
        tick(100);
        for (int i = 0; i < 40; i++) exp_q.push_back(8'(i));
        check_stream("wrap");

        // LF handling
        clear_stream();
        wr(8'h61);
        wr(8'h0A);
        tick(12);
`ifdef USB_SERIAL_TX_FIFO_CRLF_EN
        exp_q = '{8'h61, 8'h0D, 8'h0A};
`else
        exp_q = '{8'h61, 8'h0A};
`endif
        check_stream("crlf");

        // Random traffic including resets mid-drain
        for (int i = 0; i < 3000; i++) begin
            bus.wr_en         = ($urandom_range(0, 9) < 6);
            bus.wr_data       = ($urandom_range(0, 7) == 0) ? 8'h0A : 8'($urandom);
            bus.uart_tx_ready = ($urandom_range(0, 9) < 5);
            bus.clr_overflow  = ($urandom_range(0, 19) == 0);
            reset             = ($urandom_range(0, 99) != 0);
            tick();
        end
        reset     = 1'b1;
        bus.wr_en = 1'b0;
        tick(5);

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/usb_serial_tx_fifo.md
Name: usb_serial_tx_fifo

Overview:
Byte FIFO that sits directly upstream of the USB serial endpoint's transmit side and drives its uart_tx_ready/uart_tx_data/uart_tx_strobe handshake. It absorbs bursts from system logic (CPU console, debug printers) and drains them one byte at a time at the rate the endpoint accepts. It also provides a fill level and a sticky overflow flag for software.

Parameters:
DEPTH_LOG2, 4, log2 of FIFO depth; depth = 2**DEPTH_LOG2 entries (default 16)

Ports:
clk  input  1  system clock; single clock domain
reset  input  1  synchronous, active-low reset; 0 = in reset, sampled on rising clk
wr_data  input  8  byte to enqueue
wr_en  input  1  enqueue strobe; one byte per cycle while high
wr_full  output  1  FIFO holds 2**DEPTH_LOG2 bytes
wr_level  output  DEPTH_LOG2+1  number of bytes stored
overflow  output  1  sticky; set when wr_en is high while wr_full is high
clr_overflow  input  1  clears overflow
uart_tx_ready  input  1  endpoint can accept a byte; this is a registered signal that drops the cycle after a strobe
uart_tx_data  output  8  byte presented to the endpoint; valid while uart_tx_strobe is high
uart_tx_strobe  output  1  one-cycle pulse; endpoint captures uart_tx_data

Behaviour:
- Reset (reset==0 on a clk edge):
  - wr_level=0, wr_full=0, overflow=0, uart_tx_strobe=0, uart_tx_data=8'h00.
  - Read and write pointers cleared; state=IDLE.
  - Reset mid-drain discards all contents and any pending CR; no strobe is issued in the reset cycle.
- Storage: circular buffer with DEPTH_LOG2-bit pointers that wrap modulo depth. The level counter is DEPTH_LOG2+1 bits; full when level==depth, empty when level==0.
- Write:
  - If wr_en=1 and wr_full=0, store wr_data at wptr and increment wptr.
  - If wr_en=1 and wr_full=1, drop the byte, leave contents unchanged, and set overflow=1 on the next edge.
  - wr_full is evaluated on the pre-edge level. A write to a full FIFO is dropped even if a pop happens in the same cycle.
- Overflow: clr_overflow=1 clears it. If clear and set happen in the same cycle, set wins.
- Simultaneous accepted write and pop: level unchanged, both pointers advance.
- Output state machine, registered outputs:
  - IDLE: if level>0 and uart_tx_ready=1, then next edge: uart_tx_strobe=1, uart_tx_data=mem[rptr], rptr++, level--, go to HOLD. Otherwise strobe=0.
  - HOLD: strobe=0 for exactly one cycle, then IDLE. This guarantees no back-to-back strobes while the endpoint's ready flag is still catching up.
  - Peak throughput is 1 byte / 2 cycles.
  - Latency from the first write into an empty FIFO (ready=1) to strobe: 2 cycles (write edge, then strobe edge).
- Strobe is never asserted when level==0. Strobe is never asserted in a cycle where uart_tx_ready was sampled 0.
- uart_tx_data holds its last value when strobe=0.

Optional Feature:
USB_SERIAL_TX_FIFO_CRLF_EN
- Defined: when the popped byte is 8'h0A (LF), the block first emits 8'h0D (CR) without popping.
  - State CR_PEND: it then waits through HOLD and ready, and emits 8'h0A while popping.
  - Level and pointers change only on the LF emission.
  - Reset clears CR_PEND.
- Undefined: bytes pass through verbatim and the CR_PEND state is absent.

Decomposition:
- Package usb_serial_pkg: ASCII_CR=8'h0D and ASCII_LF=8'h0A constants; output state enum (IDLE, HOLD, CR_PEND).
- Sub-module usb_serial_fifo_mem: 2**DEPTH_LOG2 x 8 storage with one write port and an asynchronous read port (read data available in the same cycle as rptr). All control stays in the top module.

Test Plan:
- Reset: hold reset=0 for 3 cycles with wr_en=1 and ready=1 -> after release, wr_level=0, strobe never pulsed, overflow=0.
- Basic drain: write 8'h41, 8'h42, 8'h43 on consecutive cycles with ready=1 -> strobes with data 41, 42, 43, each separated by exactly one idle cycle; wr_level returns to 0.
- Backpressure: fill with 5 bytes, ready=0 for 20 cycles -> no strobe, wr_level=5; raise ready -> 5 strobes in order.
- Full/overflow (DEPTH_LOG2=4): write 17 bytes with ready=0 -> wr_full=1, wr_level=16, overflow=1, 17th byte absent from the drained stream. Pulse clr_overflow -> overflow=0. Repeat with a simultaneous wr_en to a full FIFO -> set wins.
- Wrap and simultaneity: stream 40 bytes 0..39 with ready toggling every 3 cycles and writes concurrent with pops -> output equals 0..39 exactly, no loss or duplication.
- CRLF (macro defined): write 8'h61, 8'h0A -> emitted 61, 0D, 0A; wr_level decrements only on 61 and 0A. With the macro undefined -> emitted 61, 0A.
